// File: rtl/gray_code_tx_if.sv
// Gray-code output bus: registered code, binary shadow and wrap flag, with valid/ready handshake.
// The master presents the code; the slave (decoder side) returns out_ready.
interface gray_code_tx_if;
  logic       ag;
  logic       bg;
  logic       cg;
  logic       dg;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] bin_out;
  logic       wrap;

  modport master (
    output ag, bg, cg, dg, out_valid, bin_out, wrap,
    input  out_ready
  );

  modport slave (
    input  ag, bg, cg, dg, out_valid, bin_out, wrap,
    output out_ready
  );
endinterface

// File: rtl/gray_code_tx.sv
// Prescaled up/down 4-bit counter presented as reflected Gray code; new code one cycle after the terminal tick.
// Holds the code while out_valid and out_ready is low, stalling the count so no step is ever dropped.
module gray_code_tx #(
  parameter  int TICK_DIV = 27_000_000,
  localparam int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           up_dn,
  input  logic           load,
  input  logic [3:0]     load_bin,
  gray_code_tx_if.master tx
);

  typedef enum logic [1:0] {IDLE, RUN, SEND} state_t;

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] presc, presc_nxt;
  logic [3:0]       bin, bin_nxt;
  logic [3:0]       gray;
  logic             wrap, wrap_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      presc <= '0;
      bin   <= 4'd0;
      gray  <= 4'd0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      bin   <= bin_nxt;
      // Gray is registered from the same next value as bin so all four bits switch on one edge.
      gray  <= bin_nxt ^ (bin_nxt >> 1);
      wrap  <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    bin_nxt   = bin;
    wrap_nxt  = 1'b0;
    case (state)
      IDLE: begin
        presc_nxt = '0;
        if (load) begin
          bin_nxt   = load_bin;
          state_nxt = SEND;
        end else if (en) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (load) begin
          bin_nxt   = load_bin;
          presc_nxt = '0;
          state_nxt = SEND;
        end else if (!en) begin
          presc_nxt = '0;
          state_nxt = IDLE;
        end else if (presc == TERM) begin
          presc_nxt = '0;
          bin_nxt   = up_dn ? bin + 4'd1 : bin - 4'd1;
          wrap_nxt  = up_dn ? (bin == 4'hF) : (bin == 4'h0);
          state_nxt = SEND;
        end else begin
          presc_nxt = presc + CNT_W'(1);
        end
      end
      SEND: begin
        // Prescaler stays frozen; load is ignored until the code is accepted.
        if (tx.out_ready) begin
          state_nxt = en ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign {tx.ag, tx.bg, tx.cg, tx.dg} = gray;
  assign tx.bin_out   = bin;
  assign tx.out_valid = (state == SEND);
  assign tx.wrap      = wrap;

endmodule

// File: tb/tb_gray_code_tx.sv
// Directed bench for gray_code_tx (TICK_DIV=4): expected codes queued at stimulus time, popped at each transfer.
module tb_gray_code_tx;

  typedef struct packed {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       wrap;
  } exp_t;

  localparam logic [3:0] GT [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_bin;
  logic [3:0] gray_obs;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  gray_code_tx_if tx ();

  gray_code_tx #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  assign gray_obs = {tx.ag, tx.bg, tx.cg, tx.dg};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] b, input logic w);
    exp_t e;
    e.bin  = b;
    e.gray = GT[b];
    e.wrap = w;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx.out_valid && n < 40);
    chk({tag, "_valid"}, tx.out_valid, 1);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_sb"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_gray"}, gray_obs, e.gray);
      chk({tag, "_bin"}, tx.bin_out, e.bin);
      chk({tag, "_wrap"}, tx.wrap, e.wrap);
    end
  endtask

  initial begin
    int         n;
    logic [3:0] prev;

    rst_n        = 1'b0;
    en           = 1'b0;
    up_dn        = 1'b1;
    load         = 1'b0;
    load_bin     = 4'd0;
    tx.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_gray", gray_obs, 4'h0);
    chk("rst_bin", tx.bin_out, 4'h0);
    chk("rst_valid", tx.out_valid, 1'b0);
    chk("rst_wrap", tx.wrap, 1'b0);

    // Sixteen free-running up steps through the full Gray sequence.
    en           = 1'b1;
    tx.out_ready = 1'b1;
    prev         = 4'h0;
    for (int i = 1; i <= 16; i++) begin
      push(4'(i), i == 16);
      wait_valid("up_step", n);
      if (i > 1) chk("up_step_lat", n, 5);
      chk("up_adj", $countones(gray_obs ^ prev), 1);
      prev = gray_obs;
      check_out("up_step");
    end

    // Slow consumer: code held while ready is low, then exactly one advance.
    @(negedge clk);
    tx.out_ready = 1'b0;
    push(4'd1, 1'b0);
    wait_valid("stall", n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_valid", tx.out_valid, 1'b1);
      chk("stall_gray", gray_obs, 4'h1);
    end
    tx.out_ready = 1'b1;
    check_out("stall");
    @(negedge clk);
    tx.out_ready = 1'b0;
    chk("accept_drop", tx.out_valid, 1'b0);
    push(4'd2, 1'b0);
    wait_valid("release", n);
    chk("release_lat", n, 4);
    @(negedge clk);
    chk("release_once", tx.bin_out, 4'd2);

    // Load during SEND is ignored.
    load     = 1'b1;
    load_bin = 4'd5;
    @(negedge clk);
    load = 1'b0;
    chk("send_load_bin", tx.bin_out, 4'd2);
    chk("send_load_valid", tx.out_valid, 1'b1);
    tx.out_ready = 1'b1;
    check_out("release");

    // Load during RUN.
    @(negedge clk);
    load     = 1'b1;
    load_bin = 4'hA;
    push(4'hA, 1'b0);
    wait_valid("load", n);
    load = 1'b0;
    chk("load_lat", n, 1);
    check_out("load");

    // Down step across 0 -> 15.
    @(negedge clk);
    load     = 1'b1;
    load_bin = 4'h0;
    up_dn    = 1'b0;
    push(4'h0, 1'b0);
    wait_valid("load0", n);
    load = 1'b0;
    check_out("load0");
    push(4'hF, 1'b1);
    wait_valid("down_wrap", n);
    chk("down_wrap_lat", n, 5);
    check_out("down_wrap");
    @(negedge clk);
    chk("wrap_pulse", tx.wrap, 1'b0);

    // en falls during SEND: handshake completes, then IDLE with bin retained.
    tx.out_ready = 1'b0;
    push(4'hE, 1'b0);
    wait_valid("en_fall", n);
    en           = 1'b0;
    tx.out_ready = 1'b1;
    check_out("en_fall");
    repeat (10) @(negedge clk);
    chk("idle_valid", tx.out_valid, 1'b0);
    chk("idle_bin", tx.bin_out, 4'hE);
    en           = 1'b1;
    tx.out_ready = 1'b0;
    push(4'hD, 1'b0);
    wait_valid("resume", n);
    chk("resume_lat", n, 5);
    check_out("resume");

    // Asynchronous reset while a code is presented.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", tx.out_valid, 1'b0);
    chk("arst_gray", gray_obs, 4'h0);
    chk("arst_bin", tx.bin_out, 4'h0);
    chk("arst_wrap", tx.wrap, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
